reg_file_bank: RTL

Parametrised multi-entry register bank: NUM_REGS entries of WIDTH bits, one byte-enabled write port, two registered read ports, and a runtime clear sequencer. It is the next generation of the team's fixed-width enabled register and serves as the general-purpose architectural and configuration register store in the datapath.

---
 rtl/reg_file_bank.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_file_bank.sv
// Multi-entry register bank: byte-enabled write port, two registered read ports, clear sequencer.
// Optional same-edge write-to-read forwarding is enabled by defining REG_FILE_BANK_BYPASS_EN.
module reg_file_bank #(
    parameter int WIDTH    = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    output logic [WIDTH-1:0]     rd_data_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_b,
    input  logic                 clr_req,
    output logic                 busy
);

    localparam int NB = WIDTH / 8;
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [WIDTH-1:0]    mem [NUM_REGS];
    logic                wr_ok;
    logic [WIDTH-1:0]    rd_next_a;
    logic [WIDTH-1:0]    rd_next_b;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] v;
        v = old;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) v[8*k +: 8] = data[8*k +: 8];
        end
        return v;
    endfunction

    // An address is backed by storage only if in range and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] a,
                                                    input logic              fwd);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_ok(a)) begin
            v = mem[a];
            if (fwd && (wr_addr == a)) v = merge_bytes(v, wr_data, wr_be);
        end
        return v;
    endfunction

    assign wr_ok = wr_en && !busy && addr_ok(wr_addr);

    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
`ifdef REG_FILE_BANK_BYPASS_EN
        rd_next_a = read_value(rd_addr_a, wr_ok);
        rd_next_b = read_value(rd_addr_b, wr_ok);
`else
        rd_next_a = read_value(rd_addr_a, 1'b0);
        rd_next_b = read_value(rd_addr_b, 1'b0);
`endif
    end

    // Storage and read registers; the clear sequence owns the entry it is zeroing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((state == CLEAR) && (clr_cnt == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    mem[i] <= merge_bytes(mem[i], wr_data, wr_be);
                end
            end
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
